// File: rtl/load_store_unit_if.sv
// Bundle between the execute stage, the load/store unit and the data memory.
// Parameter: ADDR_WIDTH, the byte/word address width.
//   req_*   request from execute  (valid/ready handshake)
//   resp_*  completion pulse back to execute (no backpressure)
//   mem_*   word-wide, single-cycle-registered data memory port
// Modports:
//   slave   the load/store unit
//   master  the surrounding environment (execute stage plus memory)
interface load_store_unit_if #(parameter int ADDR_WIDTH = 32);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_store;
  logic [2:0]            req_funct3;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic                  resp_valid;
  logic [31:0]           resp_rdata;
  logic                  resp_err;
  logic                  mem_write;
  logic                  mem_read;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic [31:0]           mem_rdata;

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_write, mem_read, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_write, mem_read, mem_addr, mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: converts byte/halfword/word accesses into whole-word
// memory accesses. Loads extract and extend the addressed lane; sub-word
// stores do a read-modify-write because the memory only writes whole words.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  load_store_unit_if.slave (request, response and memory port)
// Optional build macro:
//   LSU_MISALIGN_CHECK_EN  misaligned halfword/word accesses respond with
//                          resp_err instead of being silently truncated.

// One byte lane of the store merge: replaces the old memory byte when this
// lane is covered by the store, otherwise passes it through.
module lsu_byte_lane #(parameter int LANE = 0) (
  input  logic        isHalf,
  input  logic [1:0]  addrLo,
  input  logic [7:0]  oldByte,
  input  logic [15:0] wdata,
  output logic [7:0]  outByte
);
  localparam logic [1:0] LaneIdx = 2'(LANE);

  logic       hit;
  logic [7:0] newByte;

  // A halfword covers lanes {0,1} or {2,3}, selected by addr[1] alone.
  assign hit     = isHalf ? (addrLo[1] == LaneIdx[1]) : (addrLo == LaneIdx);
  assign newByte = (isHalf && LaneIdx[0]) ? wdata[15:8] : wdata[7:0];
  assign outByte = hit ? newByte : oldByte;
endmodule

module load_store_unit #(parameter int ADDR_WIDTH = 32) (
  input logic                clk,
  input logic                rst,
  load_store_unit_if.slave   bus
);
  localparam int NUM_LANES = 4;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {IDLE, RD, WR, LDRSP, ERR} state_t;

  typedef struct packed {
    logic                  store;
    logic [2:0]            funct3;
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           wdata;
  } req_t;

  state_t state, nextState;
  req_t   reqQ;
  logic   accept, illegal, misaligned;

  assign accept = bus.req_valid && (state == IDLE);

  // Request decode, looked at only while IDLE.
  assign illegal = (bus.req_funct3 inside {3'b011, 3'b110, 3'b111}) ||
                   (bus.req_store && (bus.req_funct3 inside {F3_BU, F3_HU}));

`ifdef LSU_MISALIGN_CHECK_EN
  assign misaligned = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                      ((bus.req_funct3 == F3_W) && (bus.req_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      reqQ  <= '0;
    end else begin
      state <= nextState;
      if (accept) begin
        reqQ.store  <= bus.req_store;
        reqQ.funct3 <= bus.req_funct3;
        reqQ.addr   <= bus.req_addr;
        reqQ.wdata  <= bus.req_wdata;
      end
    end
  end

  // Load lane extraction from the registered read data.
  logic [7:0]  ldByte;
  logic [15:0] ldHalf;
  logic [31:0] loadData;

  assign ldByte = bus.mem_rdata[{reqQ.addr[1:0], 3'b000} +: 8];
  assign ldHalf = bus.mem_rdata[{reqQ.addr[1], 4'b0000} +: 16];

  always_comb begin
    loadData = '0;
    case (reqQ.funct3)
      F3_B:    loadData = {{24{ldByte[7]}}, ldByte};
      F3_BU:   loadData = {24'd0, ldByte};
      F3_H:    loadData = {{16{ldHalf[15]}}, ldHalf};
      F3_HU:   loadData = {16'd0, ldHalf};
      F3_W:    loadData = bus.mem_rdata;
      default: loadData = '0;
    endcase
  end

  // Store merge: old word from the RD cycle with the addressed lanes replaced.
  logic [NUM_LANES-1:0][7:0] merged;

  for (genvar g = 0; g < NUM_LANES; g++) begin : gLane
    lsu_byte_lane #(.LANE(g)) uLane (
      .isHalf  (reqQ.funct3[0]),
      .addrLo  (reqQ.addr[1:0]),
      .oldByte (bus.mem_rdata[8*g +: 8]),
      .wdata   (reqQ.wdata[15:0]),
      .outByte (merged[g])
    );
  end

  logic [ADDR_WIDTH-1:0] wordAddr;
  assign wordAddr = {reqQ.addr[ADDR_WIDTH-1:2], 2'b00};

  always_comb begin
    nextState      = state;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_rdata = '0;
    bus.resp_err   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          if (illegal || misaligned)                      nextState = ERR;
          else if (bus.req_store && bus.req_funct3 == F3_W) nextState = WR;
          else                                            nextState = RD;
        end
      end
      RD: begin
        bus.mem_read = 1'b1;
        bus.mem_addr = wordAddr;
        nextState    = reqQ.store ? WR : LDRSP;
      end
      WR: begin
        bus.mem_write  = 1'b1;
        bus.mem_addr   = wordAddr;
        bus.mem_wdata  = (reqQ.funct3 == F3_W) ? reqQ.wdata : merged;
        bus.resp_valid = 1'b1;
        nextState      = IDLE;
      end
      LDRSP: begin
        bus.resp_valid = 1'b1;
        bus.resp_rdata = loadData;
        nextState      = IDLE;
      end
      ERR: begin
        bus.resp_valid = 1'b1;
        bus.resp_err   = 1'b1;
        nextState      = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed test-plan steps followed by random
// requests, every response compared against a byte-level memory model.
module tb_load_store_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  load_store_unit_if #(.ADDR_WIDTH(32)) bus();
  load_store_unit #(.ADDR_WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Physical memory behind the DUT (registered read, word write).
  logic [31:0] mem    [0:255];
  logic [31:0] refMem [0:255];

  always @(posedge clk) begin
    if (bus.mem_write) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
    if (bus.mem_read)  bus.mem_rdata <= mem[bus.mem_addr[9:2]];
  end

  int nCheck = 0;
  int nPass  = 0;
  int nFail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCheck++;
    assert (obs === exp) nPass++;
    else begin
      nFail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: what an RV32I access does to a little-endian byte memory.
  task automatic refModel(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, output bit eErr, output logic [31:0] eData,
                          output logic [31:0] eWord, output int eLat, output bit eRd,
                          output bit eWr);
    int unsigned size, sh;
    logic [31:0] w, v, mask;
    logic [7:0]  idx;
    bit bad;
    bad = (f3 == 3 || f3 == 6 || f3 == 7) || (st && (f3 == 4 || f3 == 5));
`ifdef LSU_MISALIGN_CHECK_EN
    if ((f3 % 4 == 1 && addr % 2 != 0) || (f3 == 2 && addr % 4 != 0)) bad = 1;
`endif
    idx  = 8'((addr / 4) % 256);
    w    = refMem[idx];
    size = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
    sh   = (size == 1) ? (addr % 4) * 8 : (size == 2) ? ((addr / 2) % 2) * 16 : 0;
    eErr = 0; eData = 0; eWord = 0; eRd = 0; eWr = 0; eLat = 2;
    if (bad) begin
      eErr = 1; eLat = 1;
    end else if (!st) begin
      eRd = 1;
      v = w >> sh;
      if (size == 1) v = v % 256;
      if (size == 2) v = v % 65536;
      if (f3 == 0 && v >= 128)   v = v - 32'd256;
      if (f3 == 1 && v >= 32768) v = v - 32'd65536;
      eData = v;
    end else begin
      eWr = 1;
      if (size == 4) begin
        eWord = wd; eLat = 1;
      end else begin
        eRd  = 1;
        mask = ((size == 1) ? 32'hFF : 32'hFFFF) << sh;
        eWord = (w & ~mask) | ((wd << sh) & mask);
      end
      refMem[idx] = eWord;
    end
  endtask

  // Issue one request; call at a point just after a falling edge.
  task automatic doReq(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, output logic [31:0] rdOut, output logic errOut);
    bit eErr, eRd, eWr, sawRd, sawWr, done;
    logic [31:0] eData, eWord, wAddr;
    int eLat, cyc, waitC;
    waitC = 0;
    while (bus.req_ready !== 1'b1 && waitC < 20) begin @(negedge clk); waitC++; end
    chk("req_ready_before", bus.req_ready, 1);
    refModel(st, f3, addr, wd, eErr, eData, eWord, eLat, eRd, eWr);
    wAddr = {addr[31:2], 2'b00};
    bus.req_valid = 1; bus.req_store = st; bus.req_funct3 = f3;
    bus.req_addr = addr; bus.req_wdata = wd;
    @(posedge clk); #1;
    // Garbage while busy: must be ignored.
    bus.req_store = 1'($urandom); bus.req_funct3 = 3'($urandom);
    bus.req_addr = $urandom; bus.req_wdata = $urandom;
    done = 0; cyc = 0; sawRd = 0; sawWr = 0; rdOut = 'x; errOut = 'x;
    while (!done && cyc < 10) begin
      @(negedge clk); cyc++;
      chk("rd_wr_exclusive", {31'd0, bus.mem_read & bus.mem_write}, 0);
      if (bus.mem_read === 1'b1) begin
        sawRd = 1; chk("rd_addr", bus.mem_addr, wAddr);
      end
      if (bus.mem_write === 1'b1) begin
        sawWr = 1; chk("wr_addr", bus.mem_addr, wAddr); chk("wr_data", bus.mem_wdata, eWord);
      end
      if (bus.resp_valid === 1'b1) begin
        done = 1; rdOut = bus.resp_rdata; errOut = bus.resp_err;
        bus.req_valid = 0;
      end
    end
    bus.req_valid = 0;
    chk("resp_seen", {31'd0, done}, 1);
    chk("latency", cyc, eLat);
    chk("resp_err", {31'd0, errOut}, {31'd0, eErr});
    chk("resp_rdata", rdOut, eData);
    chk("mem_read_seen", {31'd0, sawRd}, {31'd0, eRd});
    chk("mem_write_seen", {31'd0, sawWr}, {31'd0, eWr});
  endtask

  logic [31:0] rd;
  logic        er;

  initial begin
    bus.req_valid = 0; bus.req_store = 0; bus.req_funct3 = 0;
    bus.req_addr = 0; bus.req_wdata = 0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready",  bus.req_ready, 1);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_resp_err",   bus.resp_err, 0);
    chk("rst_resp_rdata", bus.resp_rdata, 0);
    chk("rst_mem_write",  bus.mem_write, 0);
    chk("rst_mem_read",   bus.mem_read, 0);
    chk("rst_mem_addr",   bus.mem_addr, 0);
    chk("rst_mem_wdata",  bus.mem_wdata, 0);
    rst = 0;
    @(negedge clk);

    // Fill the working window 0x100..0x13F.
    for (int i = 0; i < 16; i++) doReq(1, 3'b010, 32'h100 + 32'(4 * i), $urandom, rd, er);
    doReq(1, 3'b010, 32'h100, 32'h8899AABB, rd, er);

    doReq(0, 3'b000, 32'h101, 0, rd, er); chk("plan_lb",  rd, 32'hFFFFFFAA);
    doReq(0, 3'b100, 32'h103, 0, rd, er); chk("plan_lbu", rd, 32'h00000088);
    doReq(0, 3'b001, 32'h102, 0, rd, er); chk("plan_lh",  rd, 32'hFFFF8899);
    doReq(0, 3'b101, 32'h100, 0, rd, er); chk("plan_lhu", rd, 32'h0000AABB);

    doReq(1, 3'b000, 32'h102, 32'h12345677, rd, er);
    doReq(0, 3'b010, 32'h100, 0, rd, er); chk("plan_sb_readback", rd, 32'h8877AABB);

    doReq(1, 3'b010, 32'h104, 32'hDEADBEEF, rd, er);
    doReq(1, 3'b001, 32'h106, 32'h00001234, rd, er);
    doReq(0, 3'b010, 32'h104, 0, rd, er); chk("plan_sh_readback", rd, 32'h1234BEEF);

    doReq(0, 3'b011, 32'h100, 0, rd, er); chk("plan_illegal_load", {31'd0, er}, 1);
    doReq(1, 3'b100, 32'h100, 32'hFF, rd, er); chk("plan_illegal_store", {31'd0, er}, 1);

    doReq(0, 3'b010, 32'h102, 0, rd, er);
`ifdef LSU_MISALIGN_CHECK_EN
    chk("plan_misaligned_lw_err", {31'd0, er}, 1);
`else
    chk("plan_misaligned_lw_data", rd, 32'h8877AABB);
`endif

    // Reset during the RD cycle of a sub-word store: the store is abandoned.
    while (bus.req_ready !== 1'b1) @(negedge clk);
    bus.req_valid = 1; bus.req_store = 1; bus.req_funct3 = 3'b000;
    bus.req_addr = 32'h100; bus.req_wdata = 32'h55;
    @(posedge clk); #1;
    bus.req_valid = 0;
    @(negedge clk);
    chk("rstmid_in_rd", bus.mem_read, 1);
    rst = 1; #1;
    chk("rstmid_ready", bus.req_ready, 1);
    chk("rstmid_no_write", bus.mem_write, 0);
    chk("rstmid_no_read", bus.mem_read, 0);
    @(posedge clk); #1;
    chk("rstmid_no_write_edge", bus.mem_write, 0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("rstmid_word_kept", mem[8'h40], 32'h8877AABB);
    doReq(0, 3'b010, 32'h100, 0, rd, er); chk("rstmid_next_lw", rd, 32'h8877AABB);

    for (int n = 0; n < 200; n++)
      doReq(1'($urandom), 3'($urandom), 32'h100 + $urandom_range(0, 63), $urandom, rd, er);

    for (int i = 8'h40; i < 8'h50; i++) chk("final_mem", mem[i], refMem[i]);

    $display("%0d/%0d checks passed", nPass, nCheck);
    $finish;
  end
endmodule
